// File: rtl/trace_pkg.sv
// Shared encodings and entry layout for the execution-trace capture unit.
// Entry layout, LSB first: data, addr, waddr[4:0], mem_write, reg_we, pc, ts.
// Offsets are functions of the parameterised widths so every user agrees on the packing.
package trace_pkg;

    typedef enum logic [1:0] {
        MODE_ALL    = 2'd0,
        MODE_COMMIT = 2'd1,
        MODE_POST   = 2'd2,
        MODE_PRE    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int WADDR_W = 5;
    localparam int FLAG_W  = 2;

    function automatic int entry_width(input int ts_w, input int addr_w, input int data_w);
        return ts_w + 2 * addr_w + data_w + WADDR_W + FLAG_W;
    endfunction

    function automatic int off_addr(input int data_w);
        return data_w;
    endfunction

    function automatic int off_waddr(input int addr_w, input int data_w);
        return data_w + addr_w;
    endfunction

    function automatic int off_mem_write(input int addr_w, input int data_w);
        return data_w + addr_w + WADDR_W;
    endfunction

    function automatic int off_reg_we(input int addr_w, input int data_w);
        return data_w + addr_w + WADDR_W + 1;
    endfunction

    function automatic int off_pc(input int addr_w, input int data_w);
        return data_w + addr_w + WADDR_W + FLAG_W;
    endfunction

    function automatic int off_ts(input int addr_w, input int data_w);
        return data_w + 2 * addr_w + WADDR_W + FLAG_W;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge, read data follows raddr combinationally.
// Backpressure: none; the controller decides when to write and which entry to present.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array is deliberately not reset; contents are qualified by the controller's count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Execution-trace capture: records pc/writeback/store per cycle into a DEPTH-entry buffer, 4 capture modes.
// Latency: an entry written at edge N is visible first-word-fall-through on rd_data in cycle N+1.
// Backpressure: rd_valid/rd_ready readout; modes 0/1 drop new entries when full (sticky overflow), mode 3 overwrites.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ADDR_W-1:0]                   pc,
    input  logic                                reg_we,
    input  logic [4:0]                          reg_waddr,
    input  logic [DATA_W-1:0]                   reg_wdata,
    input  logic                                mem_write,
    input  logic [ADDR_W-1:0]                   mem_addr,
    input  logic [DATA_W-1:0]                   mem_wdata,
    input  logic [1:0]                          mode,
    input  logic                                arm,
    input  logic                                stop,
    input  logic [ADDR_W-1:0]                   trig_pc,
    input  logic                                rd_ready,
    output logic                                rd_valid,
    output logic [TS_W+2*ADDR_W+DATA_W+6:0]     rd_data,
    output logic [$clog2(DEPTH):0]              count,
    output logic [1:0]                          state,
    output logic                                overflow
);

    localparam int EW = entry_width(TS_W, ADDR_W, DATA_W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [ADDR_W-1:0]  trig_q, trig_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [TS_W-1:0]    ts_q, ts_d;

    logic [EW-1:0]      entry;
    logic [EW-1:0]      ram_rdata;
    logic               rd_valid_w;
    logic               pop;
    logic               push;
    logic               drop_oldest;
    logic               clr;

    // Build the entry for this cycle: a store takes precedence over the writeback value in addr/data.
    always_comb begin
        entry = {ts_q, pc, reg_we, mem_write, reg_waddr,
                 (mem_write ? mem_addr : {ADDR_W{1'b0}}),
                 (mem_write ? mem_wdata : reg_wdata)};
    end

    // Readout is live during capture for modes 0/1; triggered modes only expose data once DONE.
    assign rd_valid_w = (count_q != '0) &&
                        ((state_q == ST_DONE) || (mode_q == MODE_ALL) || (mode_q == MODE_COMMIT));
    assign pop        = rd_valid_w & rd_ready;

    // Control FSM: arming, trigger detection, capture policy per mode, overflow and timestamp.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        trig_d      = trig_q;
        ovf_d       = ovf_q;
        ts_d        = ts_q + TS_W'(1);
        push        = 1'b0;
        drop_oldest = 1'b0;
        clr         = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    clr     = 1'b1;
                    mode_d  = mode_e'(mode);
                    trig_d  = trig_pc;
                    ovf_d   = 1'b0;
                    state_d = (mode_e'(mode) == MODE_POST) ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (pc == trig_q) begin
                    push    = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                case (mode_q)
                    MODE_ALL, MODE_COMMIT: begin
                        if (stop) begin
                            state_d = ST_DONE;
                        end else if ((mode_q == MODE_ALL) || reg_we || mem_write) begin
                            // A same-cycle pop frees a slot, so a full buffer still accepts.
                            if ((count_q != FULL) || pop) begin
                                push = 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    MODE_POST: begin
                        push = 1'b1;
                        if (count_q == FULL - CW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                    default: begin
                        // Pre-trigger circular: the trigger cycle is kept, a plain stop is not.
                        if (pc == trig_q) begin
                            push    = 1'b1;
                            state_d = ST_DONE;
                        end else if (stop) begin
                            state_d = ST_DONE;
                        end else begin
                            push = 1'b1;
                        end
                        drop_oldest = push && (count_q == FULL);
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer and occupancy bookkeeping; an overwrite in circular mode retires the oldest entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop || drop_oldest) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !(pop || drop_oldest)) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers with asynchronous reset to the idle, empty condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ALL;
            trig_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ts_q     <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            trig_q   <= trig_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ts_q     <= ts_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (entry),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Unqualified RAM contents never leak out: rd_data is zero whenever nothing is valid.
    assign rd_data  = rd_valid_w ? ram_rdata : '0;
    assign rd_valid = rd_valid_w;
    assign count    = count_q;
    assign state    = state_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: DEPTH=16 instance checked every cycle against a queue model, DEPTH=4 instance
// checked by hand sequences for overflow and simultaneous push/pop; directed mode tests plus random runs.
module tb_trace_buffer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int D  = 16;
    localparam int DS = 4;
    localparam int EW = TW + 2 * AW + DW + 7;

    // Field positions within an entry, LSB first: data, addr, waddr, mem_write, reg_we, pc, ts.
    localparam int O_ADDR  = 32;
    localparam int O_WADDR = 64;
    localparam int O_MW    = 69;
    localparam int O_RW    = 70;
    localparam int O_PC    = 71;
    localparam int O_TS    = 103;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          reg_we;
    logic [4:0]    reg_waddr;
    logic [DW-1:0] reg_wdata;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mode;
    logic          arm;
    logic          stop;
    logic [AW-1:0] trig_pc;
    logic          rd_ready;
    logic          rd_ready_s;

    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [4:0]    count;
    logic [1:0]    state;
    logic          overflow;

    logic          s_rd_valid;
    logic [EW-1:0] s_rd_data;
    logic [2:0]    s_count;
    logic [1:0]    s_state;
    logic          s_overflow;

    trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .TS_W(TW)) u_dut (
        .clk(clk), .reset(reset), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mode(mode), .arm(arm), .stop(stop), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .state(state), .overflow(overflow)
    );

    trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DS), .TS_W(TW)) u_small (
        .clk(clk), .reset(reset), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mode(mode), .arm(arm), .stop(stop), .trig_pc(trig_pc), .rd_ready(rd_ready_s),
        .rd_valid(s_rd_valid), .rd_data(s_rd_data), .count(s_count), .state(s_state),
        .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model of the DEPTH=16 instance: the buffer is a plain queue, oldest at the front.
    logic [EW-1:0] mq[$];
    int            mstate;
    int            mmode;
    logic [AW-1:0] mtrig;
    bit            movf;
    logic [TW-1:0] mts;

    typedef struct {
        bit            we;
        logic [4:0]    wa;
        logic [DW-1:0] wd;
        bit            mw;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        int            exp_cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] cur_entry();
        return {mts, pc, reg_we, mem_write, reg_waddr,
                (mem_write ? mem_addr : 32'h0), (mem_write ? mem_wdata : reg_wdata)};
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) && (mstate == 3 || mmode < 2);
    endfunction

    task automatic model_reset();
        mq.delete();
        mstate = 0;
        mmode  = 0;
        mtrig  = '0;
        movf   = 1'b0;
        mts    = '0;
    endtask

    task automatic model_step();
        bit            pop;
        logic [EW-1:0] e;
        pop = m_valid() && rd_ready;
        e   = cur_entry();
        case (mstate)
            0, 3: begin
                if (arm) begin
                    mq.delete();
                    movf   = 1'b0;
                    mmode  = int'(mode);
                    mtrig  = trig_pc;
                    mstate = (mode == 2'd2) ? 1 : 2;
                end else if (pop) begin
                    void'(mq.pop_front());
                end
            end
            1: begin
                if (pc == mtrig) begin
                    mq.push_back(e);
                    mstate = 2;
                end
            end
            2: begin
                if (mmode < 2) begin
                    if (pop) void'(mq.pop_front());
                    if (stop) mstate = 3;
                    else if (mmode == 0 || reg_we || mem_write) begin
                        if (mq.size() < D) mq.push_back(e);
                        else movf = 1'b1;
                    end
                end else if (mmode == 2) begin
                    mq.push_back(e);
                    if (mq.size() == D) mstate = 3;
                end else begin
                    if (pc == mtrig || !stop) begin
                        mq.push_back(e);
                        if (mq.size() > D) void'(mq.pop_front());
                    end
                    if (pc == mtrig || stop) mstate = 3;
                end
            end
            default: ;
        endcase
        mts = mts + 16'd1;
    endtask

    task automatic check_outputs();
        logic [EW-1:0] exp_d;
        exp_d = m_valid() ? mq[0] : '0;
        chk("state", 128'(state), 128'(mstate));
        chk("count", 128'(count), 128'(mq.size()));
        chk("overflow", 128'(overflow), 128'(movf));
        chk("rd_valid", 128'(rd_valid), 128'(m_valid()));
        chk("rd_data", 128'(rd_data), 128'(exp_d));
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc = '0; reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
        mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [AW-1:0] t);
        arm = 1'b1; mode = m; trig_pc = t;
        tick();
        arm = 1'b0;
    endtask

    task automatic pop_one(output logic [EW-1:0] e);
        rd_ready = 1'b1;
        chk("pop_valid", 128'(rd_valid), 128'(1));
        e = rd_data;
        tick();
        rd_ready = 1'b0;
    endtask

    function automatic logic [AW-1:0] f_pc(input logic [EW-1:0] e);
        return e[O_PC +: AW];
    endfunction

    function automatic logic [TW-1:0] f_ts(input logic [EW-1:0] e);
        return e[O_TS +: TW];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt[10];
        logic [EW-1:0] e;
        logic [TW-1:0] ts0;
        logic [TW-1:0] sts[$];

        idle_inputs();
        mode = 2'd0; trig_pc = '0; rd_ready_s = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_valid", 128'(rd_valid), 128'(0));
        chk("rst_data", 128'(rd_data), 128'(0));
        reset = 1'b0;

        // Mode 0: four cycles captured, stop cycle not captured.
        do_arm(2'd0, '0);
        ts0 = mts;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(4 * i);
            tick();
        end
        pc = 32'h100; stop = 1'b1;
        tick();
        stop = 1'b0; pc = '0;
        chk("m0_state", 128'(state), 128'(3));
        chk("m0_count", 128'(count), 128'(4));
        for (int i = 0; i < 4; i++) begin
            pop_one(e);
            chk("m0_pc", 128'(f_pc(e)), 128'(4 * i));
            chk("m0_ts", 128'(f_ts(e)), 128'(ts0 + 16'(i)));
        end
        chk("m0_empty", 128'(count), 128'(0));

        // Mode 1: table of ten cycles, only writeback/store cycles recorded.
        for (int i = 0; i < 10; i++) begin
            vt[i].we = 1'b0; vt[i].wa = 5'd0; vt[i].wd = $urandom;
            vt[i].mw = 1'b0; vt[i].ma = $urandom; vt[i].md = $urandom;
        end
        vt[1].we = 1'b1; vt[1].wa = 5'd8; vt[1].wd = 32'd5;
        vt[3].mw = 1'b1; vt[3].ma = 32'h8; vt[3].md = 32'd12;
        vt[6].we = 1'b1; vt[6].wa = 5'd9; vt[6].wd = 32'd7;
        vt[0].exp_cnt = 0; vt[1].exp_cnt = 0; vt[2].exp_cnt = 1; vt[3].exp_cnt = 1;
        vt[4].exp_cnt = 2; vt[5].exp_cnt = 2; vt[6].exp_cnt = 2; vt[7].exp_cnt = 3;
        vt[8].exp_cnt = 3; vt[9].exp_cnt = 3;
        do_arm(2'd1, '0);
        for (int i = 0; i < 10; i++) begin
            pc = 32'(4 * i); reg_we = vt[i].we; reg_waddr = vt[i].wa; reg_wdata = vt[i].wd;
            mem_write = vt[i].mw; mem_addr = vt[i].ma; mem_wdata = vt[i].md;
            chk("m1_count", 128'(count), 128'(vt[i].exp_cnt));
            tick();
        end
        idle_inputs();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (vt[i].we || vt[i].mw) begin
                pop_one(e);
                chk("m1_reg_we", 128'(e[O_RW]), 128'(vt[i].we));
                chk("m1_mem_write", 128'(e[O_MW]), 128'(vt[i].mw));
                chk("m1_waddr", 128'(e[O_WADDR +: 5]), 128'(vt[i].wa));
                chk("m1_addr", 128'(e[O_ADDR +: AW]), 128'(vt[i].mw ? vt[i].ma : 32'h0));
                chk("m1_data", 128'(e[0 +: DW]), 128'(vt[i].mw ? vt[i].md : vt[i].wd));
            end
        end
        chk("m1_empty", 128'(count), 128'(0));

        // Mode 2: wait in ARMED for pc 0x20, then exactly DEPTH entries.
        do_arm(2'd2, 32'h20);
        for (int i = 0; i < 4; i++) begin
            pc = 32'h10 + 32'(4 * i);
            chk("m2_armed", 128'(state), 128'(1));
            tick();
        end
        for (int i = 0; i < D; i++) begin
            pc = 32'h20 + 32'(4 * i);
            chk("m2_no_valid", 128'(rd_valid), 128'(0));
            tick();
        end
        pc = '0;
        chk("m2_done", 128'(state), 128'(3));
        chk("m2_valid", 128'(rd_valid), 128'(1));
        chk("m2_count", 128'(count), 128'(16));
        for (int i = 0; i < D; i++) begin
            pop_one(e);
            chk("m2_pc", 128'(f_pc(e)), 128'(32'h20 + 32'(4 * i)));
        end

        // Mode 3: 40 cycles, trigger on the 40th, keep cycles 25..40.
        do_arm(2'd3, 32'h100 + 32'(4 * 40));
        for (int c = 1; c <= 40; c++) begin
            pc = 32'h100 + 32'(4 * c);
            chk("m3_no_valid", 128'(rd_valid), 128'(0));
            tick();
        end
        pc = '0;
        chk("m3_done", 128'(state), 128'(3));
        chk("m3_count", 128'(count), 128'(16));
        for (int i = 0; i < D; i++) begin
            pop_one(e);
            chk("m3_pc", 128'(f_pc(e)), 128'(32'h100 + 32'(4 * (25 + i))));
        end

        // DEPTH=4: overflow without readout.
        do_arm(2'd0, '0);
        for (int i = 0; i < 6; i++) begin
            pc = 32'(i);
            tick();
        end
        chk("ovf_count", 128'(s_count), 128'(4));
        chk("ovf_flag", 128'(s_overflow), 128'(1));
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // DEPTH=4: full buffer with readout held, nothing may be dropped.
        do_arm(2'd0, '0);
        ts0 = mts;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i);
            tick();
        end
        chk("pp_full", 128'(s_count), 128'(4));
        chk("pp_ovf0", 128'(s_overflow), 128'(0));
        rd_ready_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sts.push_back(f_ts(s_rd_data));
            tick();
            chk("pp_count", 128'(s_count), 128'(4));
            chk("pp_ovf", 128'(s_overflow), 128'(0));
        end
        rd_ready_s = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        rd_ready_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain_valid", 128'(s_rd_valid), 128'(1));
            sts.push_back(f_ts(s_rd_data));
            tick();
        end
        rd_ready_s = 1'b0;
        chk("pp_empty", 128'(s_count), 128'(0));
        for (int i = 0; i < 8; i++) begin
            chk("pp_ts_seq", 128'(sts[i]), 128'(ts0 + 16'(i)));
        end

        // Asynchronous reset mid-capture, then a normal re-arm.
        do_arm(2'd0, '0);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_state", 128'(state), 128'(0));
        chk("ar_count", 128'(count), 128'(0));
        chk("ar_valid", 128'(rd_valid), 128'(0));
        chk("ar_data", 128'(rd_data), 128'(0));
        chk("ar_s_state", 128'(s_state), 128'(0));
        chk("ar_s_count", 128'(s_count), 128'(0));
        chk("ar_s_ovf", 128'(s_overflow), 128'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        do_arm(2'd0, '0);
        pc = 32'h40;
        tick();
        pc = 32'h44;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("ar_rearm_count", 128'(count), 128'(2));
        pop_one(e);
        chk("ar_first_ts", 128'(f_ts(e)), 128'(1));
        chk("ar_first_pc", 128'(f_pc(e)), 128'(32'h40));
        pop_one(e);
        chk("ar_second_ts", 128'(f_ts(e)), 128'(2));

        // Random runs checked against the model every cycle.
        for (int r = 0; r < 40; r++) begin
            idle_inputs();
            do_arm(2'($urandom_range(0, 3)), 32'($urandom_range(0, 15) * 4));
            for (int c = 0; c < 50; c++) begin
                pc         = 32'($urandom_range(0, 15) * 4);
                reg_we     = 1'($urandom_range(0, 1));
                reg_waddr  = 5'($urandom);
                reg_wdata  = $urandom;
                mem_write  = ($urandom_range(0, 3) == 0);
                mem_addr   = $urandom;
                mem_wdata  = $urandom;
                stop       = ($urandom_range(0, 15) == 0);
                arm        = ($urandom_range(0, 39) == 0);
                mode       = 2'($urandom_range(0, 3));
                trig_pc    = 32'($urandom_range(0, 15) * 4);
                rd_ready   = 1'($urandom_range(0, 1));
                rd_ready_s = 1'($urandom_range(0, 1));
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
